// File: rtl/fpu_pkg.sv
// Shared FPU definitions: float field layout, one-hot status codes and FSM states.
package fpu_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 25;
  localparam int MANT_W   = 25;
  localparam int EXP_W    = 6;

  typedef enum logic [3:0] {
    ST_NONE      = 4'b0000,
    ST_EXACT     = 4'b0001,
    ST_INEXACT   = 4'b0010,
    ST_OVERFLOW  = 4'b0100,
    ST_UNDERFLOW = 4'b1000
  } status_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASSIFY,
    S_SHIFT,
    S_ROUND,
    S_DONE
  } conv_state_t;

  function automatic logic [31:0] pack_float(input logic             sign,
                                             input logic [EXP_W-1:0]  exp,
                                             input logic [MANT_W-1:0] mant);
    return {sign, exp, mant};
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits an FPU float word into its fields and flags zero / denormal encodings.
module fp_unpack
  import fpu_pkg::*;
(
  input  logic [31:0]       i_word,
  output logic              o_sign,
  output logic [EXP_W-1:0]  o_exp,
  output logic [MANT_W-1:0] o_mant,
  output logic              o_is_zero,
  output logic              o_is_denorm
);

  assign o_sign      = i_word[SIGN_BIT];
  assign o_exp       = i_word[EXP_MSB:EXP_LSB];
  assign o_mant      = i_word[MANT_W-1:0];
  assign o_is_zero   = (i_word[EXP_MSB:0] == '0);
  assign o_is_denorm = (o_exp == '0) && (o_mant != '0);

endmodule

// File: rtl/fpu_to_int.sv
// Iterative float-to-int converter: classifies the word, shifts the significand one
// bit per cycle up to the binary point, then rounds and saturates into a status code.
module fpu_to_int
  import fpu_pkg::*;
#(
  parameter int BIAS       = 31,
  parameter int ROUND_MODE = 0
) (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_out,
  output logic [3:0]  status_out
);

  conv_state_t r_state, w_next_state;
  logic [31:0] r_op;
  logic [56:0] r_w;
  logic [4:0]  r_cnt;
  logic [31:0] r_data;
  status_t     r_status;
  logic        r_out_valid;

  logic              w_sign, w_is_zero, w_is_denorm;
  logic [EXP_W-1:0]  w_exp;
  logic [MANT_W-1:0] w_mant;
  logic signed [6:0] w_unb;

  fp_unpack u_unpack (
    .i_word      (r_op),
    .o_sign      (w_sign),
    .o_exp       (w_exp),
    .o_mant      (w_mant),
    .o_is_zero   (w_is_zero),
    .o_is_denorm (w_is_denorm)
  );

  assign w_unb = $signed({1'b0, w_exp}) - $signed(7'(BIAS));

  // Words that never reach the shifter resolve straight from the exponent.
  logic        w_special;
  logic [31:0] w_spec_data;
  status_t     w_spec_status;

  always_comb begin
    w_special     = 1'b1;
    w_spec_data   = '0;
    w_spec_status = ST_EXACT;
    if (w_is_zero) begin
      w_spec_status = ST_EXACT;
    end else if (w_is_denorm) begin
      w_spec_status = ST_UNDERFLOW;
    end else if ((w_unb > 7'sd31) || ((w_unb == 7'sd31) && !(w_sign && (w_mant == '0)))) begin
      w_spec_status = ST_OVERFLOW;
    end else if (w_unb == 7'sd31) begin
      w_spec_data   = 32'h8000_0000;
    end else if (w_unb < 7'sd0) begin
      w_spec_status = ST_INEXACT;
      if ((ROUND_MODE == 1) && (w_unb == -7'sd1))
        w_spec_data = w_sign ? 32'hFFFF_FFFF : 32'd1;
    end else begin
      w_special     = 1'b0;
    end
  end

  // Magnitude is 33 bits so the rounding increment cannot wrap.
  logic        w_rnd, w_inexact, w_ovf;
  logic [32:0] w_mag;
  logic [31:0] w_round_data;
  status_t     w_round_status;

  always_comb begin
    w_rnd          = (ROUND_MODE == 1) && r_w[24];
    w_mag          = {1'b0, r_w[56:25]} + {32'b0, w_rnd};
    w_inexact      = (r_w[24:0] != '0);
    w_ovf          = w_sign ? (w_mag > 33'h0_8000_0000) : (w_mag > 33'h0_7FFF_FFFF);
    w_round_data   = '0;
    w_round_status = ST_EXACT;
    if (w_ovf) begin
      w_round_status = ST_OVERFLOW;
    end else begin
      w_round_data   = w_sign ? (~w_mag[31:0] + 32'd1) : w_mag[31:0];
      w_round_status = w_inexact ? ST_INEXACT : ST_EXACT;
    end
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (in_valid) w_next_state = S_CLASSIFY;
      S_CLASSIFY: begin
        if (w_special)            w_next_state = S_DONE;
        else if (w_unb[4:0] != 0) w_next_state = S_SHIFT;
        else                      w_next_state = S_ROUND;
      end
      S_SHIFT:    if (r_cnt == 5'd1) w_next_state = S_ROUND;
      S_ROUND:    w_next_state = S_DONE;
      S_DONE:     if (r_out_valid && out_ready) w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // out_valid rises one cycle after entering DONE, giving the registered result a settle cycle.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      r_op        <= '0;
      r_w         <= '0;
      r_cnt       <= '0;
      r_data      <= '0;
      r_status    <= ST_NONE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) r_op <= op_in;
        S_CLASSIFY: begin
          r_w   <= {31'b0, 1'b1, w_mant};
          r_cnt <= w_unb[4:0];
          if (w_special) begin
            r_data   <= w_spec_data;
            r_status <= w_spec_status;
          end
        end
        S_SHIFT: begin
          r_w   <= r_w << 1;
          r_cnt <= r_cnt - 5'd1;
        end
        S_ROUND: begin
          r_data   <= w_round_data;
          r_status <= w_round_status;
        end
        S_DONE: begin
          if (!r_out_valid)   r_out_valid <= 1'b1;
          else if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = r_out_valid;
  assign data_out   = r_data;
  assign status_out = r_status;

endmodule

// File: tb/tb_fpu_to_int.sv
// Scoreboard bench for fpu_to_int: truncating and rounding instances share stimulus,
// an arithmetic reference model predicts value, status and latency per word.
module tb_fpu_to_int;
  import fpu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        inValid = 1'b0;
  logic [31:0] opIn = '0;
  logic        outReady = 1'b0;
  logic        inReady0, inReady1, outValid0, outValid1;
  logic [31:0] dataOut0, dataOut1;
  logic [3:0]  statusOut0, statusOut1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit randReady = 1'b0;
  bit prevValid = 1'b0;

  typedef struct {
    logic [31:0] data0;
    logic [3:0]  st0;
    logic [31:0] data1;
    logic [3:0]  st1;
    int          expEdge;
  } expect_t;

  expect_t scoreQ[$];
  expect_t popped;

  fpu_to_int #(.BIAS(31), .ROUND_MODE(0)) dut0 (
    .clock100KHz(clock), .reset(reset), .in_valid(inValid), .in_ready(inReady0),
    .op_in(opIn), .out_valid(outValid0), .out_ready(outReady),
    .data_out(dataOut0), .status_out(statusOut0)
  );

  fpu_to_int #(.BIAS(31), .ROUND_MODE(1)) dut1 (
    .clock100KHz(clock), .reset(reset), .in_valid(inValid), .in_ready(inReady1),
    .op_in(opIn), .out_valid(outValid1), .out_ready(outReady),
    .data_out(dataOut1), .status_out(statusOut1)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  always @(negedge clock) if (randReady) outReady = ($urandom_range(0, 3) != 0);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Value = 1.m * 2^(exp-31), evaluated with wide integer arithmetic.
  task automatic refConvert(input logic [31:0] w, input bit rm,
                            output logic [31:0] data, output logic [3:0] st, output int lat);
    longint full, mag, rem;
    int e, sh;
    bit inexact;
    e = int'(w[30:25]) - 31;
    data = '0;
    if (w[30:0] == 0) begin
      st = ST_EXACT; lat = 2;
    end else if (w[30:25] == 0) begin
      st = ST_UNDERFLOW; lat = 2;
    end else begin
      lat = (e < 0 || e >= 31) ? 2 : e + 3;
      full = (64'd1 << 25) | longint'(w[24:0]);
      if (e >= 25) begin
        mag = full << (e - 25);
        inexact = 1'b0;
      end else begin
        sh = 25 - e;
        mag = full >> sh;
        rem = full & ((64'd1 << sh) - 1);
        inexact = (rem != 0);
        if (rm && rem >= (64'd1 << (sh - 1))) mag = mag + 1;
      end
      if ((!w[31] && mag > 64'd2147483647) || (w[31] && mag > 64'd2147483648)) begin
        st = ST_OVERFLOW;
      end else begin
        data = w[31] ? 32'(-mag) : 32'(mag);
        st = inexact ? ST_INEXACT : ST_EXACT;
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] word);
    expect_t ex;
    int lat0, lat1, waitCnt;
    waitCnt = 0;
    @(negedge clock);
    while (!inReady0 && waitCnt < 200) begin
      @(negedge clock);
      waitCnt++;
    end
    if (!inReady0) begin
      checkOutput("in_ready timeout", 32'(inReady0), 32'd1);
      return;
    end
    refConvert(word, 1'b0, ex.data0, ex.st0, lat0);
    refConvert(word, 1'b1, ex.data1, ex.st1, lat1);
    inValid = 1'b1;
    opIn = word;
    @(posedge clock);
    #1;
    ex.expEdge = cyc + lat0;
    scoreQ.push_back(ex);
    inValid = 1'b0;
    opIn = $urandom;
  endtask

  task automatic checkResetState();
    checkOutput("rst out_valid", 32'(outValid0), 32'd0);
    checkOutput("rst in_ready", 32'(inReady0), 32'd1);
    checkOutput("rst data_out", dataOut0, 32'd0);
    checkOutput("rst status_out", 32'(statusOut0), 32'd0);
    checkOutput("rst out_valid rm1", 32'(outValid1), 32'd0);
    checkOutput("rst status_out rm1", 32'(statusOut1), 32'd0);
  endtask

  // Monitor: compare once per result, on the first cycle out_valid is seen.
  always @(negedge clock) begin
    if (reset && outValid0 && !prevValid) begin
      if (scoreQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected output: got data 0x%08h, expected no output", dataOut0);
      end else begin
        popped = scoreQ.pop_front();
        checkOutput("data rm0", dataOut0, popped.data0);
        checkOutput("status rm0", 32'(statusOut0), 32'(popped.st0));
        checkOutput("data rm1", dataOut1, popped.data1);
        checkOutput("status rm1", 32'(statusOut1), 32'(popped.st1));
        checkOutput("valid rm1", 32'(outValid1), 32'd1);
        checkOutput("latency edge", 32'(cyc), 32'(popped.expEdge));
      end
    end
    prevValid = outValid0;
  end

  initial begin
    logic [31:0] directed [7];
    int waitCnt;
    directed = '{32'h4280_0000, 32'hC080_0000, 32'h7C00_0000, 32'hFC00_0000,
                 32'h3C00_0000, 32'h0000_0001, 32'h0000_0000};

    repeat (3) @(negedge clock);
    checkResetState();
    reset = 1'b1;
    outReady = 1'b1;

    foreach (directed[i]) applyStimulus(directed[i]);

    randReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [5:0] ex;
      ex = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(26, 61));
      applyStimulus(pack_float(1'($urandom), ex, 25'($urandom)));
    end

    // Hold the result unaccepted and poke in_valid while it waits.
    randReady = 1'b0;
    @(negedge clock);
    outReady = 1'b1;
    waitCnt = 0;
    while (!inReady0 && waitCnt < 200) begin @(negedge clock); waitCnt++; end
    outReady = 1'b0;
    applyStimulus(32'h4280_0000);
    waitCnt = 0;
    while (!outValid0 && waitCnt < 60) begin @(negedge clock); waitCnt++; end
    checkOutput("hold out_valid rise", 32'(outValid0), 32'd1);
    for (int i = 0; i < 10; i++) begin
      inValid = (i == 3 || i == 6);
      opIn = 32'h3E00_0000;
      @(negedge clock);
      checkOutput("hold data", dataOut0, 32'd5);
      checkOutput("hold status", 32'(statusOut0), 32'(ST_EXACT));
      checkOutput("hold in_ready", 32'(inReady0), 32'd0);
      checkOutput("hold out_valid", 32'(outValid0), 32'd1);
    end
    inValid = 1'b0;
    outReady = 1'b1;
    @(negedge clock);
    checkOutput("release out_valid", 32'(outValid0), 32'd0);
    checkOutput("release in_ready", 32'(inReady0), 32'd1);
    repeat (4) @(negedge clock);

    // Reset in the middle of a long shift.
    applyStimulus(32'h7A00_0000);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    scoreQ.delete();
    checkResetState();
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(32'h4280_0000);
    applyStimulus(32'hC080_0000);
    applyStimulus(32'h3E00_0000);

    waitCnt = 0;
    while (scoreQ.size() != 0 && waitCnt < 500) begin @(negedge clock); waitCnt++; end
    checkOutput("drain pending", 32'(scoreQ.size()), 32'd0);
    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
